test_if_top: RTL and testbench

TEST_IF_TOP -- requirements
Module: test_if_top

---
 rtl/test_if_top.sv | 121 ++++++++++++
 tb/tb_test_if_top.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/test_if_top.sv
// rtl/test_if_top.sv - instruction fetch stage driving a synchronous instruction ROM
// ifetch owns the PC and the output valid; the ROM register supplies the instruction.

module ifetch #(
  parameter int ADDR = 32,
  parameter int INST = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] baddr_i,
  input  logic [INST-1:0] inst_i,
  output logic [ADDR-1:0] addr_o,
  output logic            rd_en_o,
  output logic [INST-1:0] inst_o,
  output logic [ADDR-1:0] origaddr_o,
  output logic            v_o
);

  logic [ADDR-1:0] pc;

  assign addr_o  = pc;
  assign inst_o  = inst_i;
  // The ROM register and origaddr_o move together so inst_o always pairs with origaddr_o.
  assign rd_en_o = branch_i | ~stall_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      origaddr_o <= '0;
      v_o        <= 1'b0;
    end else if (branch_i) begin
      pc         <= baddr_i;
      origaddr_o <= pc;
      v_o        <= 1'b0;
    end else if (!stall_i) begin
      origaddr_o <= pc;
      v_o        <= v_i;
      if (v_i) begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

module inst_rom #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [ADDR-1:0] addr,
  output logic [INST-1:0] data
);

  logic [ADDR-1:0] idx;
  logic [INST-1:0] word;

  // Contents are a fixed pattern: high half DEAD, low half the word index.
  assign idx  = addr % ADDR'(DEPTH);
  assign word = INST'({16'hDEAD, idx[15:0]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= word;
    end
  end

endmodule

module test_if_top #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] baddr_i,
  output logic [INST-1:0] inst_o,
  output logic [ADDR-1:0] origaddr_o,
  output logic            v_o
);

  logic [ADDR-1:0] rom_addr;
  logic            rom_en;
  logic [INST-1:0] rom_data;

  ifetch #(.ADDR(ADDR), .INST(INST)) ifetch1 (
    .clk        (clk),
    .rst        (rst),
    .v_i        (v_i),
    .stall_i    (stall_i),
    .branch_i   (branch_i),
    .baddr_i    (baddr_i),
    .inst_i     (rom_data),
    .addr_o     (rom_addr),
    .rd_en_o    (rom_en),
    .inst_o     (inst_o),
    .origaddr_o (origaddr_o),
    .v_o        (v_o)
  );

  inst_rom #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) rom1 (
    .clk  (clk),
    .rst  (rst),
    .en   (rom_en),
    .addr (rom_addr),
    .data (rom_data)
  );

endmodule

// File: tb/tb_test_if_top.sv
// tb/tb_test_if_top.sv - randomized self-checking bench for test_if_top
// Expected outputs come from a stream-level model of the fetch rules.

module tb_test_if_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] baddr_i = '0;
  logic [31:0] inst_o;
  logic [31:0] origaddr_o;
  logic        v_o;

  int vectors = 0;
  int miscompares = 0;

  // model state: next fetch address, and the currently presented fetch
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_valid;

  test_if_top dut (
    .clk        (clk),
    .rst        (rst),
    .v_i        (v_i),
    .stall_i    (stall_i),
    .branch_i   (branch_i),
    .baddr_i    (baddr_i),
    .inst_o     (inst_o),
    .origaddr_o (origaddr_o),
    .v_o        (v_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_of(input logic [31:0] a);
    return 32'hDEAD0000 + (a % 256);
  endfunction

  task automatic check_outputs();
    check("v_o", {31'b0, v_o}, {31'b0, m_valid});
    check("addr_o", dut.ifetch1.addr_o, m_pc);
    if (m_valid) begin
      check("origaddr_o", origaddr_o, m_addr);
      check("inst_o", inst_o, rom_of(m_addr));
    end
  endtask

  // one clock with the given inputs; entered and left at the falling edge
  task automatic cycle(input logic v, input logic s, input logic b, input logic [31:0] ba);
    v_i = v; stall_i = s; branch_i = b; baddr_i = ba;
    @(posedge clk); #1;
    if (b) begin
      m_valid = 1'b0;
      m_pc = ba;
    end else if (!s) begin
      if (v) begin
        m_valid = 1'b1;
        m_addr = m_pc;
        m_pc = m_pc + 1;
      end else begin
        m_valid = 1'b0;
      end
    end
    check_outputs();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_v"}, {31'b0, v_o}, 32'd0);
    check({tag, "_orig"}, origaddr_o, 32'd0);
    check({tag, "_inst"}, inst_o, 32'd0);
    check({tag, "_pc"}, dut.ifetch1.addr_o, 32'd0);
  endtask

  initial begin
    m_pc = 0; m_addr = 0; m_valid = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // free run, then branch to 2
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0);
    check("free_inst", inst_o, 32'hDEAD0003);
    cycle(1, 0, 1, 32'd2);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
    check("after_branch_orig", origaddr_o, 32'd4);
    cycle(1, 0, 0, 0);
    // stall while presenting address 5
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0);
    check("stall_inst", inst_o, 32'hDEAD0005);
    cycle(1, 0, 0, 0);
    // branch with stall, branch wins
    cycle(1, 1, 1, 32'h10);
    cycle(1, 0, 0, 0);
    check("bstall_orig", origaddr_o, 32'h10);
    // fetch disable
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("resume_orig", origaddr_o, 32'h11);
    // back-to-back branches and PC wrap
    cycle(1, 0, 1, 32'h40);
    cycle(1, 0, 1, 32'hFFFFFFFF);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("wrap_orig", origaddr_o, 32'd0);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    m_pc = 0; m_valid = 0; m_addr = 0;
    @(negedge clk);
    branch_i = 1'b1; stall_i = 1'b1;
    @(negedge clk);
    check_reset_state("rst_override");
    rst = 1'b0;
    cycle(1, 0, 0, 0);
    check("restart_inst", inst_o, 32'hDEAD0000);

    for (int n = 0; n < 400; n++) begin
      logic v, s, b;
      logic [31:0] ba;
      v = ($urandom % 8) != 0;
      s = ($urandom % 5) == 0;
      b = ($urandom % 10) == 0;
      case ($urandom % 4)
        0: ba = 32'hFFFFFFFD + ($urandom % 3);
        1: ba = $urandom;
        default: ba = $urandom_range(0, 600);
      endcase
      cycle(v, s, b, ba);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
